// File: rtl/alu_operand_fetch_pkg.sv
// Shared definitions for the ALU operand-fetch stage and its neighbours.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package alu_operand_fetch_pkg;

  // Instruction word layout
  localparam int INSTR_W  = 16;
  localparam int FUNC_MSB = 15;
  localparam int FUNC_LSB = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RS1_MSB  = 7;
  localparam int RS1_LSB  = 5;
  localparam int RS2_MSB  = 4;
  localparam int RS2_LSB  = 2;

  // Field widths and register-file geometry
  localparam int FUNC_W = FUNC_MSB - FUNC_LSB + 1;
  localparam int REG_AW = RD_MSB - RD_LSB + 1;
  localparam int NREG   = 1 << REG_AW;

  typedef logic [FUNC_W-1:0] func_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  // Packed view of the instruction word; field order matches the bit positions above.
  typedef struct packed {
    func_t     func;
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic [1:0] pad;
  } instr_t;

  // ALU function codes, shared with the ALU and its bench.
  localparam func_t FN_ADD   = 5'd0;
  localparam func_t FN_SUB   = 5'd1;
  localparam func_t FN_MUL   = 5'd2;
  localparam func_t FN_AND   = 5'd3;
  localparam func_t FN_OR    = 5'd4;
  localparam func_t FN_XOR   = 5'd5;
  localparam func_t FN_PASSA = 5'd6;
  localparam func_t FN_PASSB = 5'd7;

  // One-hot mask selecting a single register in the busy scoreboard.
  function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t a);
    return NREG'(1) << a;
  endfunction

endpackage

// File: rtl/aof_regfile.sv
// 8 x N register file: two combinational read ports, one write port, write bypass on reads.
// Latency: reads are combinational; writes land on the next rising edge.
// Backpressure: none; the write port always accepts.
module aof_regfile
  import alu_operand_fetch_pkg::*;
#(
  parameter int N = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [N-1:0]      rdata1,
  output logic [N-1:0]      rdata2
);

  logic [N-1:0] regs_q [NREG];
  logic [N-1:0] regs_d [NREG];
  logic         wr_en;

  // r0 is hardwired to zero, so writes aimed at it are dropped here.
  assign wr_en = we && (waddr != '0);

  // Next-state of the storage array: only the addressed entry changes.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Storage array, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: a same-cycle write to the same register is forwarded.
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (wr_en && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (raddr1 == '0) begin
      rdata1 = '0;
    end
  end

  // Read port 2: same forwarding rule as port 1.
  always_comb begin
    rdata2 = regs_q[raddr2];
    if (wr_en && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
    if (raddr2 == '0) begin
      rdata2 = '0;
    end
  end

endmodule

// File: rtl/alu_operand_fetch.sv
// Decodes instructions, fetches operands with a busy scoreboard, issues A/B/func to the ALU.
// Latency: accepted instruction appears on issue_* 1 cycle later; writeback lands next edge.
// Backpressure: one-entry issue slot holds while !issue_ready; instr_ready drops on full slot or hazard.
module alu_operand_fetch
  import alu_operand_fetch_pkg::*;
#(
  parameter int N = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [N-1:0]      A,
  output logic [N-1:0]      B,
  output logic [FUNC_W-1:0] func,
  output logic [REG_AW-1:0] issue_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [N*N-1:0]    wb_data,
  output logic              wb_ovf
);

  instr_t            instr_f;
  logic [N-1:0]      rs1_dat;
  logic [N-1:0]      rs2_dat;
  logic              wb_hit;
  logic [NREG-1:0]   wb_clr;
  logic [NREG-1:0]   busy_eff;
  logic              hazard;
  logic              accept;
  logic              wb_upper_nz;
  logic              unused_pad;

  logic              issue_valid_q, issue_valid_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [REG_AW-1:0] issue_rd_q, issue_rd_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wb_ovf_q, wb_ovf_d;

  assign instr_f    = instr_t'(instr);
  assign unused_pad = ^instr_f.pad;

  // Register file; its bypass hands same-cycle writeback data straight to the operand reads.
  aof_regfile #(
    .N(N)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_data[N-1:0]),
    .raddr1 (instr_f.rs1),
    .raddr2 (instr_f.rs2),
    .rdata1 (rs1_dat),
    .rdata2 (rs2_dat)
  );

  // A writeback landing this cycle resolves its register's hazard immediately.
  always_comb begin
    wb_hit      = wb_valid && (wb_rd != '0);
    wb_clr      = wb_hit ? reg_onehot(wb_rd) : '0;
    busy_eff    = busy_q & ~wb_clr;
    hazard      = busy_eff[instr_f.rs1] | busy_eff[instr_f.rs2] | busy_eff[instr_f.rd];
    instr_ready = (!issue_valid_q || issue_ready) && !hazard;
    accept      = instr_valid && instr_ready;
    wb_upper_nz = |wb_data[N*N-1:N];
  end

  // Issue slot: load on accept, drain when consumed without refill, otherwise hold.
  always_comb begin
    issue_valid_d = issue_valid_q;
    a_d           = a_q;
    b_d           = b_q;
    func_d        = func_q;
    issue_rd_d    = issue_rd_q;
    if (accept) begin
      issue_valid_d = 1'b1;
      a_d           = rs1_dat;
      b_d           = rs2_dat;
      func_d        = instr_f.func;
      issue_rd_d    = instr_f.rd;
    end else if (issue_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  // Scoreboard and overflow flag: clear is applied before set so a same-rd issue keeps the bit.
  always_comb begin
    busy_d   = busy_q & ~wb_clr;
    wb_ovf_d = wb_ovf_q;
    if (accept && (instr_f.rd != '0)) begin
      busy_d = busy_d | reg_onehot(instr_f.rd);
    end
    if (wb_hit && wb_upper_nz) begin
      wb_ovf_d = 1'b1;
    end
  end

  // State registers; reset drops any pending issue and clears the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      func_q        <= '0;
      issue_rd_q    <= '0;
      busy_q        <= '0;
      wb_ovf_q      <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      a_q           <= a_d;
      b_q           <= b_d;
      func_q        <= func_d;
      issue_rd_q    <= issue_rd_d;
      busy_q        <= busy_d;
      wb_ovf_q      <= wb_ovf_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign A           = a_q;
  assign B           = b_q;
  assign func        = func_q;
  assign issue_rd    = issue_rd_q;
  assign wb_ovf      = wb_ovf_q;

endmodule
